// File: rtl/rob_pkg.sv
// rob_pkg: shared sizes, entry record and tag type for the multi-port reorder buffer
package rob_pkg;
  localparam int ROB_DEPTH = 16;
  localparam int ROB_WB_PORTS = 2;
  localparam int ROB_QRY_PORTS = 2;
  localparam int DATA_W = 32;
  localparam int REG_W = 5;
  localparam int OP_W = 6;
  localparam int TAG_W = $clog2(ROB_DEPTH);
  typedef logic [TAG_W-1:0] tag_t;
  typedef struct packed {
    logic valid;
    logic ready;
    logic [REG_W-1:0] rd;
    logic [OP_W-1:0] op;
    logic [DATA_W-1:0] val;
  } rob_entry_t;
endpackage

// File: rtl/rob_wb_select.sv
// rob_wb_select: finds the lowest-index writeback port targeting a tag and returns its data
module rob_wb_select #(
  parameter int PORTS = 2,
  parameter int TAG_W = 4,
  parameter int DATA_W = 32
) (
  input  logic [PORTS-1:0]        wb_valid,
  input  logic [PORTS*TAG_W-1:0]  wb_tag,
  input  logic [PORTS*DATA_W-1:0] wb_data,
  input  logic [TAG_W-1:0]        tag,
  output logic                    hit,
  output logic [DATA_W-1:0]       data
);
  // scan from the highest port down so the lowest matching port overwrites last
  always_comb begin
    hit = 1'b0;
    data = '0;
    for (int i = PORTS - 1; i >= 0; i--)
      if (wb_valid[i] && wb_tag[i*TAG_W +: TAG_W] == tag) begin
        hit = 1'b1;
        data = wb_data[i*DATA_W +: DATA_W];
      end
  end
endmodule

// File: rtl/rob_mp.sv
// rob_mp: reorder buffer with multi-port writeback, bypassed operand lookup and in-order commit
module rob_mp import rob_pkg::*; #(
  parameter int DEPTH = ROB_DEPTH,
  parameter int WB_PORTS = ROB_WB_PORTS,
  parameter int QRY_PORTS = ROB_QRY_PORTS,
  localparam int TW = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       alloc_valid,
  output logic                       alloc_ready,
  input  logic [REG_W-1:0]           alloc_rd,
  input  logic [OP_W-1:0]            alloc_op,
  output logic [TW-1:0]              alloc_tag,
  input  logic [WB_PORTS-1:0]        wb_valid,
  input  logic [WB_PORTS*TW-1:0]     wb_tag,
  input  logic [WB_PORTS*DATA_W-1:0] wb_data,
  input  logic [QRY_PORTS*TW-1:0]    qry_tag,
  output logic [QRY_PORTS-1:0]       qry_ready,
  output logic [QRY_PORTS*DATA_W-1:0] qry_data,
  output logic                       commit_valid,
  input  logic                       commit_ready,
  output logic [REG_W-1:0]           commit_rd,
  output logic [OP_W-1:0]            commit_op,
  output logic [DATA_W-1:0]          commit_data,
  output logic [TW-1:0]              commit_tag,
  output logic [TW:0]                count,
  output logic                       empty
);
  rob_entry_t ent [DEPTH];
  logic [TW-1:0] head, tail;
  logic [TW:0] cnt;
  logic alloc_fire, commit_fire;
  logic [DEPTH-1:0] e_hit;
  logic [DATA_W-1:0] e_wd [DEPTH];
  assign alloc_ready = cnt != (TW+1)'(DEPTH);
  assign alloc_fire = alloc_valid && alloc_ready && !flush;
  assign alloc_tag = tail;
  assign commit_valid = ent[head].valid && ent[head].ready && !flush;
  assign commit_fire = commit_valid && commit_ready;
  assign commit_rd = ent[head].rd;
  assign commit_op = ent[head].op;
  assign commit_data = ent[head].val;
  assign commit_tag = head;
  assign count = cnt;
  assign empty = cnt == '0;
  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    rob_wb_select #(.PORTS(WB_PORTS), .TAG_W(TW), .DATA_W(DATA_W)) u_sel (
      .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
      .tag(TW'(e)), .hit(e_hit[e]), .data(e_wd[e])
    );
  end
  for (genvar q = 0; q < QRY_PORTS; q++) begin : g_qry
    logic q_hit;
    logic [DATA_W-1:0] q_wd;
    rob_entry_t qe;
    assign qe = ent[qry_tag[q*TW +: TW]];
    rob_wb_select #(.PORTS(WB_PORTS), .TAG_W(TW), .DATA_W(DATA_W)) u_sel (
      .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
      .tag(qry_tag[q*TW +: TW]), .hit(q_hit), .data(q_wd)
    );
    assign qry_ready[q] = qe.valid && (q_hit || qe.ready);
    assign qry_data[q*DATA_W +: DATA_W] = !qe.valid ? '0 : q_hit ? q_wd : qe.val;
  end
  // entry storage and pointers; flush squashes everything, count alone distinguishes full from empty
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (e_hit[i] && ent[i].valid) begin
          ent[i].ready <= 1'b1;
          ent[i].val <= e_wd[i];
        end
      if (commit_fire) begin
        ent[head].valid <= 1'b0;
        head <= head + TW'(1);
      end
      if (alloc_fire) begin
        ent[tail].valid <= 1'b1;
        ent[tail].ready <= 1'b0;
        ent[tail].rd <= alloc_rd;
        ent[tail].op <= alloc_op;
        tail <= tail + TW'(1);
      end
      cnt <= cnt + (TW+1)'(alloc_fire) - (TW+1)'(commit_fire);
    end
  end
endmodule

// File: tb/tb_rob_mp.sv
// tb_rob_mp: directed scenarios plus random traffic checked against an in-order queue model
module tb_rob_mp;
  logic clk = 0, rst = 0, flush = 0, alloc_valid = 0, commit_ready = 0;
  logic [4:0] alloc_rd = 0;
  logic [5:0] alloc_op = 0;
  logic alloc_ready, commit_valid, empty;
  logic [3:0] alloc_tag, commit_tag;
  logic [1:0] wb_valid = 0;
  logic [7:0] wb_tag = 0, qry_tag = 0;
  logic [63:0] wb_data = 0;
  logic [1:0] qry_ready;
  logic [63:0] qry_data;
  logic [4:0] commit_rd, count;
  logic [5:0] commit_op;
  logic [31:0] commit_data;
  rob_mp dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_rd(alloc_rd), .alloc_op(alloc_op), .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .qry_tag(qry_tag), .qry_ready(qry_ready), .qry_data(qry_data),
    .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_rd(commit_rd), .commit_op(commit_op),
    .commit_data(commit_data), .commit_tag(commit_tag), .count(count), .empty(empty)
  );
  always #5 clk = ~clk;
  int passed = 0, total = 0;
  bit mv [16];
  bit md [16];
  logic [31:0] mval [16];
  logic [4:0] mrd [16];
  logic [5:0] mop [16];
  int q [$];
  int ntail;
  bit ecv;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    else passed++;
  endtask
  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      mv[i] = 0;
      md[i] = 0;
      mval[i] = 0;
    end
    q.delete();
    ntail = 0;
  endtask
  task automatic check_outputs();
    ecv = !flush && q.size() > 0 && md[q[0]];
    check("alloc_ready", alloc_ready, q.size() != 16);
    check("alloc_tag", alloc_tag, ntail);
    check("count", count, q.size());
    check("empty", empty, q.size() == 0);
    check("commit_valid", commit_valid, ecv);
    if (ecv) begin
      check("commit_tag", commit_tag, q[0]);
      check("commit_data", commit_data, mval[q[0]]);
      check("commit_rd", commit_rd, mrd[q[0]]);
      check("commit_op", commit_op, mop[q[0]]);
    end
    for (int p = 0; p < 2; p++) begin
      int t;
      bit er;
      logic [31:0] ed;
      t = int'(qry_tag[p*4 +: 4]);
      er = 0;
      ed = 0;
      if (mv[t]) begin
        er = md[t];
        ed = mval[t];
        for (int w = 0; w < 2; w++)
          if (wb_valid[w] && int'(wb_tag[w*4 +: 4]) == t) begin
            er = 1;
            ed = wb_data[w*32 +: 32];
            break;
          end
      end
      check($sformatf("qry%0d_ready", p), qry_ready[p], er);
      if (er || !mv[t]) check($sformatf("qry%0d_data", p), qry_data[p*32 +: 32], ed);
    end
  endtask
  task automatic model_update();
    bit full;
    bit seen [16];
    if (flush) begin
      for (int i = 0; i < 16; i++) mv[i] = 0;
      q.delete();
      ntail = 0;
    end else begin
      full = q.size() == 16;
      for (int i = 0; i < 16; i++) seen[i] = 0;
      for (int w = 0; w < 2; w++) begin
        int t;
        t = int'(wb_tag[w*4 +: 4]);
        if (wb_valid[w] && mv[t] && !seen[t]) begin
          md[t] = 1;
          mval[t] = wb_data[w*32 +: 32];
          seen[t] = 1;
        end
      end
      if (ecv && commit_ready) begin
        mv[q[0]] = 0;
        void'(q.pop_front());
      end
      if (alloc_valid && !full) begin
        mv[ntail] = 1;
        md[ntail] = 0;
        mrd[ntail] = alloc_rd;
        mop[ntail] = alloc_op;
        q.push_back(ntail);
        ntail = (ntail + 1) % 16;
      end
    end
  endtask
  task automatic step();
    #1;
    check_outputs();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic idle();
    flush = 0;
    alloc_valid = 0;
    commit_ready = 0;
    wb_valid = 0;
    qry_tag = 0;
  endtask
  task automatic set_wb(input int p, input int t, input logic [31:0] d);
    wb_valid[p] = 1;
    wb_tag[p*4 +: 4] = 4'(t);
    wb_data[p*32 +: 32] = d;
  endtask
  task automatic do_reset();
    idle();
    #3;
    rst = 0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    rst = 1;
  endtask
  task automatic alloc_n(input int n);
    for (int i = 0; i < n; i++) begin
      idle();
      alloc_valid = 1;
      alloc_rd = 5'($urandom);
      alloc_op = 6'($urandom);
      step();
    end
  endtask
  function automatic int pick_tag();
    return (q.size() > 0 && $urandom_range(3) != 0) ? q[$urandom_range(q.size() - 1)] : int'($urandom_range(15));
  endfunction
  initial begin
    model_reset();
    idle();
    @(negedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst = 1;
    for (int i = 1; i <= 3; i++) begin
      idle();
      alloc_valid = 1;
      alloc_rd = 5'(i);
      alloc_op = 6'(i + 10);
      step();
    end
    idle();
    step();
    idle();
    set_wb(0, 1, 32'haa);
    step();
    idle();
    set_wb(1, 0, 32'h55);
    step();
    idle();
    commit_ready = 1;
    step();
    step();
    step();
    do_reset();
    alloc_n(16);
    idle();
    set_wb(0, 0, 32'h1234);
    step();
    idle();
    commit_ready = 1;
    alloc_valid = 1;
    step();
    idle();
    alloc_valid = 1;
    step();
    idle();
    set_wb(0, 2, 32'h11);
    set_wb(1, 2, 32'h22);
    qry_tag = 8'h22;
    step();
    idle();
    qry_tag = 8'h22;
    step();
    do_reset();
    alloc_n(5);
    idle();
    set_wb(0, 0, 32'h77);
    step();
    idle();
    step();
    idle();
    flush = 1;
    alloc_valid = 1;
    commit_ready = 1;
    step();
    idle();
    step();
    alloc_n(1);
    idle();
    set_wb(0, 0, 32'hbeef);
    step();
    idle();
    qry_tag = 8'h00;
    repeat (4) step();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      idle();
      flush = $urandom_range(49) == 0;
      alloc_valid = $urandom_range(3) != 0;
      alloc_rd = 5'($urandom);
      alloc_op = 6'($urandom);
      commit_ready = $urandom_range(2) != 0;
      for (int w = 0; w < 2; w++)
        if ($urandom_range(1) == 1) set_wb(w, pick_tag(), $urandom);
      if ($urandom_range(3) == 0) begin
        wb_valid = 2'b11;
        wb_tag[7:4] = wb_tag[3:0];
      end
      qry_tag[3:0] = 4'(pick_tag());
      qry_tag[7:4] = 4'(wb_valid[0] && $urandom_range(1) == 1 ? int'(wb_tag[3:0]) : pick_tag());
      step();
      if (c == 1500) do_reset();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
